// File: rtl/traffic_light_sequencer_if.sv
// Bundle between the phase sequencer and its host/controller side.
// master drives run/clear/ped/value; slave (sequencer) drives the phase outputs.
interface traffic_light_sequencer_if;
  logic       i_run;
  logic       i_clear;
  logic       i_ped_req;
  logic [6:0] i_value;
  logic [1:0] o_state;
  logic       o_en;
  logic       o_fault;
  logic       o_phase_done;
  logic       o_ped_ack;
  logic [7:0] o_cycle_count;

  modport master (
    output i_run, i_clear, i_ped_req, i_value,
    input  o_state, o_en, o_fault,
    input  o_phase_done, o_ped_ack, o_cycle_count
  );

  modport slave (
    input  i_run, i_clear, i_ped_req, i_value,
    output o_state, o_en, o_fault,
    output o_phase_done, o_ped_ack, o_cycle_count
  );
endinterface

// File: rtl/traffic_light_sequencer.sv
// Traffic light phase sequencer: RED->GREEN->YELLOW on countdown expiry,
// per-phase watchdog with latched FAULT, pedestrian request latch/ack.
// Ports: i_clk, i_reset (sync, active-high), bus (slave modport):
//   in : i_run, i_clear, i_ped_req, i_value[6:0]
//   out: o_state[1:0], o_en, o_fault, o_phase_done, o_ped_ack,
//        o_cycle_count[7:0] (all registered)
module traffic_light_sequencer #(
  parameter int unsigned ARM_TIMEOUT = 16,
  parameter int unsigned MAX_PHASE   = 32'd1_000_000_000,
  parameter int unsigned WD_WIDTH    = 32
) (
  input logic                        i_clk,
  input logic                        i_reset,
  traffic_light_sequencer_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RED    = 3'd1;
  localparam logic [2:0] S_GREEN  = 3'd2;
  localparam logic [2:0] S_YELLOW = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [1:0] C_OFF = 2'b00;
  localparam logic [1:0] C_RED = 2'b01;
  localparam logic [1:0] C_YEL = 2'b10;
  localparam logic [1:0] C_GRN = 2'b11;

  localparam logic [WD_WIDTH-1:0] WD_ARM =
    WD_WIDTH'(ARM_TIMEOUT - 1);
  localparam logic [WD_WIDTH-1:0] WD_MAX =
    WD_WIDTH'(MAX_PHASE - 1);
  localparam logic [WD_WIDTH-1:0] WD_ONE =
    WD_WIDTH'(1);

  logic [2:0]          state_q, state_d;
  logic                armed_q, armed_d;
  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic                ped_q, ped_d;
  logic [1:0]          st_q, st_d;
  logic                en_q, en_d;
  logic                fault_q, fault_d;
  logic                done_q, done_d;
  logic                ack_q, ack_d;
  logic [7:0]          cnt_q, cnt_d;

  logic running;
  logic expire;
  logic wd_trip;

  assign running = (state_q == S_RED) ||
                   (state_q == S_GREEN) ||
                   (state_q == S_YELLOW);

  // armed_q is last cycle's view, so a stale zero on the first
  // cycle of a new phase never counts as expiry.
  assign expire  = armed_q && (bus.i_value == 7'd0);
  assign wd_trip = (!armed_q && (wd_q == WD_ARM)) ||
                   (wd_q == WD_MAX);

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    wd_d    = wd_q;
    ped_d   = ped_q |
              (bus.i_ped_req && (state_q != S_FAULT));
    done_d  = 1'b0;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_run) state_d = S_RED;
      end
      S_RED, S_GREEN, S_YELLOW: begin
        if (wd_trip) begin
          state_d = S_FAULT;
          armed_d = 1'b0;
          wd_d    = '0;
          ped_d   = 1'b0;
        end else if (!bus.i_run) begin
          state_d = S_IDLE;
          armed_d = 1'b0;
          wd_d    = '0;
        end else if (expire) begin
          armed_d = 1'b0;
          wd_d    = '0;
          done_d  = 1'b1;
          if (state_q == S_RED) begin
            state_d = S_GREEN;
          end else if (state_q == S_GREEN) begin
            state_d = S_YELLOW;
          end else begin
            state_d = S_RED;
            cnt_d   = cnt_q + 8'd1;
          end
        end else begin
          wd_d    = wd_q + WD_ONE;
          armed_d = armed_q | (bus.i_value != 7'd0);
        end
      end
      S_FAULT: begin
        if (bus.i_clear) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        armed_d = 1'b0;
        wd_d    = '0;
      end
    endcase

    // Serve a pending (or same-cycle) request on any RED entry.
    if ((state_d == S_RED) && (state_q != S_RED) && ped_d) begin
      ack_d = 1'b1;
      ped_d = 1'b0;
    end

    st_d    = C_OFF;
    en_d    = 1'b0;
    fault_d = 1'b0;
    unique case (state_d)
      S_RED:    begin st_d = C_RED; en_d = 1'b1; end
      S_GREEN:  begin st_d = C_GRN; en_d = 1'b1; end
      S_YELLOW: begin st_d = C_YEL; en_d = 1'b1; end
      S_FAULT:  fault_d = 1'b1;
      default:  st_d = C_OFF;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      wd_q    <= '0;
      ped_q   <= 1'b0;
      st_q    <= C_OFF;
      en_q    <= 1'b0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      wd_q    <= wd_d;
      ped_q   <= ped_d;
      st_q    <= st_d;
      en_q    <= en_d;
      fault_q <= fault_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.o_state       = st_q;
  assign bus.o_en          = en_q;
  assign bus.o_fault       = fault_q;
  assign bus.o_phase_done  = done_q;
  assign bus.o_ped_ack     = ack_q;
  assign bus.o_cycle_count = cnt_q;

endmodule
